gardner_ted: RTL and testbench

- Gardner timing-error detector for complex baseband (I/Q) symbol timing recovery.
- Decimates the ADC stream to 2 samples per symbol: alternating on-time and mid-symbol samples.
- Produces one signed error value per symbol, with a one-cycle valid strobe.
- Sits between the ADC/matched-filter front end and the loop filter / NCO of the timing-recovery loop.

---
 rtl/gardner_ted_pkg.sv | 13 +
 rtl/gardner_sat_mac.sv | 47 ++++
 rtl/gardner_ted.sv | 83 ++++++++
 tb/tb_gardner_ted.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gardner_ted_pkg.sv
// Shared constants for the Gardner timing-error detector: error width,
// saturation limits and the two-phase capture encoding.
package gardner_ted_pkg;

    localparam int ER_W = 32;

    localparam logic signed [ER_W-1:0] ER_MAX = 32'sh7fff_ffff;
    localparam logic signed [ER_W-1:0] ER_MIN = 32'sh8000_0000;

    localparam logic [0:0] PH_ONTIME = 1'b0;
    localparam logic [0:0] PH_MID    = 1'b1;

endpackage

// File: rtl/gardner_sat_mac.sv
// Combinational Gardner error term: mid_I*(prev_I-cur_I) + mid_Q*(prev_Q-cur_Q),
// computed at full precision and saturated to a signed 32-bit result.
module gardner_sat_mac
    import gardner_ted_pkg::*;
#(
    parameter int width = 15
) (
    input  logic signed [width:0]  prev_i,
    input  logic signed [width:0]  prev_q,
    input  logic signed [width:0]  cur_i,
    input  logic signed [width:0]  cur_q,
    input  logic signed [width:0]  mid_i,
    input  logic signed [width:0]  mid_q,
    output logic signed [ER_W-1:0] er
);

    localparam int DW = width + 2;
    localparam int PW = 2 * width + 3;
    localparam int SW = 2 * width + 4;
    // Comparison width: wide enough for the full sum and for the 32-bit limits.
    localparam int EW = (SW > ER_W + 1) ? SW : ER_W + 1;

    logic signed [DW-1:0] diff_i;
    logic signed [DW-1:0] diff_q;
    logic signed [PW-1:0] prod_i;
    logic signed [PW-1:0] prod_q;
    logic signed [SW-1:0] sum;
    logic signed [EW-1:0] sum_ext;

    assign diff_i  = DW'(prev_i) - DW'(cur_i);
    assign diff_q  = DW'(prev_q) - DW'(cur_q);
    assign prod_i  = PW'(mid_i) * PW'(diff_i);
    assign prod_q  = PW'(mid_q) * PW'(diff_q);
    assign sum     = SW'(prod_i) + SW'(prod_q);
    assign sum_ext = EW'(sum);

    always_comb begin
        // NOTE: default assignment first so every path drives er and no latch is inferred.
        er = sum_ext[ER_W-1:0];
        if (sum_ext > EW'(ER_MAX)) begin
            er = ER_MAX;
        end else if (sum_ext < EW'(ER_MIN)) begin
            er = ER_MIN;
        end
    end

endmodule

// File: rtl/gardner_ted.sv
// Gardner timing-error detector: decimates I/Q to two samples per symbol and
// emits one saturated error per symbol with a single-cycle valid strobe.
module gardner_ted
    import gardner_ted_pkg::*;
#(
    parameter int width      = 15,
    parameter int sample_div = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [width:0]  I_adc,
    input  logic signed [width:0]  Q_adc,
    output logic signed [ER_W-1:0] er,
    output logic                   ted_out_en
);

    localparam int CW = (sample_div > 1) ? $clog2(sample_div) : 1;

    logic [CW-1:0]          div_cnt;
    logic [0:0]             phase;
    logic                   primed;
    logic signed [width:0]  prev_i;
    logic signed [width:0]  prev_q;
    logic signed [width:0]  mid_i;
    logic signed [width:0]  mid_q;
    logic signed [ER_W-1:0] er_next;
    logic                   capture;

    assign capture = (div_cnt == '0);

    gardner_sat_mac #(
        .width (width)
    ) u_mac (
        .prev_i (prev_i),
        .prev_q (prev_q),
        .cur_i  (I_adc),
        .cur_q  (Q_adc),
        .mid_i  (mid_i),
        .mid_q  (mid_q),
        .er     (er_next)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            phase      <= PH_ONTIME;
            primed     <= 1'b0;
            prev_i     <= '0;
            prev_q     <= '0;
            mid_i      <= '0;
            mid_q      <= '0;
            er         <= '0;
            ted_out_en <= 1'b0;
        end else begin
            ted_out_en <= 1'b0;

            if (div_cnt == CW'(sample_div - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (capture) begin
                phase <= ~phase;
                if (phase == PH_MID) begin
                    mid_i <= I_adc;
                    mid_q <= Q_adc;
                end else begin
                    // The error needs a previous on-time sample, so the first on-time capture only primes.
                    if (primed) begin
                        er         <= er_next;
                        ted_out_en <= 1'b1;
                    end
                    prev_i <= I_adc;
                    prev_q <= Q_adc;
                    primed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gardner_ted.sv
// Directed self-checking bench for gardner_ted at the default rate and at
// sample_div=1, with hand-computed error values.
module tb_gardner_ted;

    logic               clk;
    logic               reset;
    logic signed [15:0] i_adc;
    logic signed [15:0] q_adc;
    logic signed [31:0] er;
    logic               ted_out_en;

    logic               rst_f;
    logic signed [15:0] i_f;
    logic signed [15:0] q_f;
    logic signed [31:0] er_f;
    logic               en_f;

    int n_checks;
    int n_fail;

    int seq_i  [0:31];
    int seq_q  [0:31];
    int exp_er [0:31];

    gardner_ted #(
        .width      (15),
        .sample_div (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .I_adc      (i_adc),
        .Q_adc      (q_adc),
        .er         (er),
        .ted_out_en (ted_out_en)
    );

    gardner_ted #(
        .width      (15),
        .sample_div (1)
    ) dut_fast (
        .clk        (clk),
        .reset      (rst_f),
        .I_adc      (i_f),
        .Q_adc      (q_f),
        .er         (er_f),
        .ted_out_en (en_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_cap(input int c);
        i_adc = 16'(seq_i[c]);
        q_adc = 16'(seq_q[c]);
    endtask

    // Releases reset 5 ns before a rising edge and plays n_caps captures of
    // sample_div=10 clocks each, checking the strobe and er on every clock.
    task automatic play_seq(input int n_caps, input string tag);
        int exp_cur;
        bit exp_en;
        exp_cur = 0;
        @(negedge clk);
        drive_cap(0);
        reset = 1'b0;
        for (int k = 0; k < 10 * n_caps; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_en = (k % 20 == 0) && (k >= 20);
            if (exp_en) exp_cur = exp_er[k / 10];
            n_checks++;
            if (ted_out_en !== exp_en) begin
                n_fail++;
                $display("FAIL %s strobe clk %0d: got %b expected %b", tag, k, ted_out_en, exp_en);
            end
            n_checks++;
            if (er !== exp_cur) begin
                n_fail++;
                $display("FAIL %s er clk %0d: got %0d expected %0d", tag, k, er, exp_cur);
            end
            if ((k + 1) % 10 == 0 && (k + 1) / 10 < n_caps) drive_cap((k + 1) / 10);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            i_adc = 16'($urandom);
            q_adc = 16'($urandom);
            repeat (4) @(negedge clk);
            n_checks++;
            if (er !== 32'sd0) begin
                n_fail++;
                $display("FAIL reset er: got %0d expected 0", er);
            end
            n_checks++;
            if (ted_out_en !== 1'b0) begin
                n_fail++;
                $display("FAIL reset strobe: got %b expected 0", ted_out_en);
            end
        end
    endtask

    task automatic load_default();
        seq_i[0] = -792;  seq_q[0] = 838;
        seq_i[1] = -1000; seq_q[1] = 1000;
        seq_i[2] = -727;  seq_q[2] = 806;
        seq_i[3] = 822;   seq_q[3] = -725;
        seq_i[4] = 1000;  seq_q[4] = -1000;
        exp_er[2] = 97000;
        exp_er[4] = -2728944;
    endtask

    task automatic test_default_pattern();
        reset = 1'b1;
        load_default();
        play_seq(5, "default");
    endtask

    task automatic test_async_reset();
        n_checks++;
        if (er !== -32'sd2728944) begin
            n_fail++;
            $display("FAIL async_reset pre er: got %0d expected -2728944", er);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (er !== 32'sd0) begin
            n_fail++;
            $display("FAIL async_reset er: got %0d expected 0", er);
        end
        n_checks++;
        if (ted_out_en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset strobe: got %b expected 0", ted_out_en);
        end
        load_default();
        play_seq(5, "after_reset");
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        seq_i[0] = 32767;  seq_q[0] = 32767;
        seq_i[1] = 32767;  seq_q[1] = 32767;
        seq_i[2] = -32768; seq_q[2] = -32768;
        exp_er[2] = 2147483647;
        play_seq(3, "sat_pos");

        reset = 1'b1;
        seq_i[1] = -32768; seq_q[1] = -32768;
        exp_er[2] = 32'sh8000_0000;
        play_seq(3, "sat_neg");
    endtask

    // On-time samples alternate (100,-50)/(-100,50) with mid (5,3): errors alternate +700/-700.
    task automatic test_strobe_spacing();
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 1) begin
                seq_i[c] = 5;
                seq_q[c] = 3;
            end else if ((c / 2) % 2 == 0) begin
                seq_i[c] = 100;
                seq_q[c] = -50;
                exp_er[c] = -700;
            end else begin
                seq_i[c] = -100;
                seq_q[c] = 50;
                exp_er[c] = 700;
            end
        end
        play_seq(20, "spacing");
    endtask

    task automatic test_fast_rate();
        bit exp_en;
        rst_f = 1'b1;
        i_f   = 16'sd1000;
        q_f   = 16'sd1000;
        @(negedge clk);
        rst_f = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_en = (k % 2 == 0) && (k >= 2);
            n_checks++;
            if (en_f !== exp_en) begin
                n_fail++;
                $display("FAIL fast strobe clk %0d: got %b expected %b", k, en_f, exp_en);
            end
            n_checks++;
            if (er_f !== 32'sd0) begin
                n_fail++;
                $display("FAIL fast er clk %0d: got %0d expected 0", k, er_f);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        rst_f    = 1'b1;
        i_adc    = '0;
        q_adc    = '0;
        i_f      = '0;
        q_f      = '0;
        for (int c = 0; c < 32; c++) begin
            seq_i[c]  = 0;
            seq_q[c]  = 0;
            exp_er[c] = 0;
        end

        test_reset();
        test_default_pattern();
        test_async_reset();
        test_saturation();
        test_strobe_spacing();
        test_fast_rate();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
